// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup block: RGB struct,
// default palette colours and the init/run state encoding.
package palette_pkg;

  localparam int CH_W = 10;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  localparam rgb_t WHITE        = '{r: {CH_W{1'b1}}, g: {CH_W{1'b1}}, b: {CH_W{1'b1}}};
  localparam rgb_t BLACK        = '{r: {CH_W{1'b0}}, g: {CH_W{1'b0}}, b: {CH_W{1'b0}}};
  localparam rgb_t RED          = '{r: {CH_W{1'b1}}, g: {CH_W{1'b0}}, b: {CH_W{1'b0}}};
  localparam rgb_t BLUE         = '{r: {CH_W{1'b0}}, g: {CH_W{1'b0}}, b: {CH_W{1'b1}}};
  localparam rgb_t CURSOR_GREEN = '{r: {CH_W{1'b0}}, g: {CH_W{1'b1}}, b: {CH_W{1'b0}}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/palette_regfile.sv
// Register-file palette storage: one synchronous write port and two
// asynchronous read ports (drawing colour and framebuffer pixel).
module palette_regfile #(
  parameter int IDX_W = 2,
  parameter int CH_W  = 10
) (
  input  logic                Clk,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_widx,
  input  logic [3*CH_W-1:0]   i_wdata,
  input  logic [IDX_W-1:0]    i_ridx_a,
  output logic [3*CH_W-1:0]   o_rdata_a,
  input  logic [IDX_W-1:0]    i_ridx_b,
  output logic [3*CH_W-1:0]   o_rdata_b
);

  localparam int N = 1 << IDX_W;

  logic [3*CH_W-1:0] r_mem [N];

  // Entry storage; contents are only meaningful once INIT has written them.
  always_ff @(posedge Clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_ridx_a];
  assign o_rdata_b = r_mem[i_ridx_b];

endmodule

// File: rtl/palette_lut.sv
// Palette lookup with overlay priority and a 2-cycle pixel pipeline.
// INIT loads default colours one entry per cycle after Reset, then RUN
// accepts user palette writes. Optional cursor blink is enabled by
// defining PALETTE_CURSOR_BLINK_EN.
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W        = 2,
  parameter int CH_W         = 10,
  parameter int BLINK_FRAMES = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [IDX_W-1:0]  sel_idx,
  output logic [IDX_W-1:0]  fb_wr_idx,
  input  logic              pix_valid,
  input  logic [IDX_W-1:0]  pix_idx,
  input  logic              is_cursor,
  input  logic              is_palette,
  input  logic              is_border,
  input  logic              frame_tick,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [CH_W-1:0]   wr_r,
  input  logic [CH_W-1:0]   wr_g,
  input  logic [CH_W-1:0]   wr_b,
  output logic              out_valid,
  output logic [CH_W-1:0]   VGA_R,
  output logic [CH_W-1:0]   VGA_G,
  output logic [CH_W-1:0]   VGA_B
);

  localparam int N  = 1 << IDX_W;
  localparam int PW = 3 * CH_W;

  // Package colours are saturated per channel; widen them to CH_W.
  function automatic logic [PW-1:0] expand(input rgb_t c);
    return {{CH_W{|c.r}}, {CH_W{|c.g}}, {CH_W{|c.b}}};
  endfunction

  localparam logic [PW-1:0] C_WHITE = expand(WHITE);
  localparam logic [PW-1:0] C_BLACK = expand(BLACK);
  localparam logic [PW-1:0] C_RED   = expand(RED);
  localparam logic [PW-1:0] C_BLUE  = expand(BLUE);
  localparam logic [PW-1:0] C_GREEN = expand(CURSOR_GREEN);

  // Default palette contents loaded by INIT.
  function automatic logic [PW-1:0] default_rgb(input logic [IDX_W-1:0] idx);
    case (32'(idx))
      32'd0:   return C_WHITE;
      32'd1:   return C_BLACK;
      32'd2:   return C_RED;
      32'd3:   return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

  state_t            r_state;
  state_t            w_next_state;
  logic [IDX_W-1:0]  r_init_cnt;
  logic              w_init_active;
  logic              w_we;
  logic [IDX_W-1:0]  w_widx;
  logic [PW-1:0]     w_wdata;

  logic              r_s1_valid;
  logic [IDX_W-1:0]  r_s1_pix_idx;
  logic [IDX_W-1:0]  r_s1_sel_idx;
  logic              r_s1_cursor;
  logic              r_s1_palette;
  logic              r_s1_border;

  logic [PW-1:0]     w_rd_sel;
  logic [PW-1:0]     w_rd_pix;
  logic [PW-1:0]     w_sel_rgb;
  logic [PW-1:0]     w_pix_rgb;
  logic [PW-1:0]     w_color;
  logic              w_cursor_vis;

  assign fb_wr_idx = sel_idx;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: leave INIT once the last entry is being written.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == IDX_W'(N - 1)) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_INIT;
        end
      end
      ST_RUN:  w_next_state = ST_RUN;
      default: w_next_state = ST_INIT;
    endcase
  end

  // State decode for handshake and init masking.
  always_comb begin
    wr_ready      = 1'b0;
    w_init_active = 1'b0;
    case (r_state)
      ST_INIT: w_init_active = 1'b1;
      ST_RUN:  wr_ready      = 1'b1;
      default: w_init_active = 1'b1;
    endcase
  end

  // INIT entry counter, restarted at 0 by every Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_init_cnt <= '0;
    end else if (w_init_active) begin
      r_init_cnt <= r_init_cnt + IDX_W'(1);
    end else begin
      r_init_cnt <= r_init_cnt;
    end
  end

  // Single write port shared by INIT defaults and user writes; a request
  // pending while Reset is high is dropped.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = wr_idx;
    w_wdata = {wr_r, wr_g, wr_b};
    if (Reset) begin
      w_we = 1'b0;
    end else if (w_init_active) begin
      w_we    = 1'b1;
      w_widx  = r_init_cnt;
      w_wdata = default_rgb(r_init_cnt);
    end else begin
      w_we = wr_valid & wr_ready;
    end
  end

  palette_regfile #(
    .IDX_W (IDX_W),
    .CH_W  (CH_W)
  ) u_regfile (
    .Clk       (Clk),
    .i_we      (w_we),
    .i_widx    (w_widx),
    .i_wdata   (w_wdata),
    .i_ridx_a  (r_s1_sel_idx),
    .o_rdata_a (w_rd_sel),
    .i_ridx_b  (r_s1_pix_idx),
    .o_rdata_b (w_rd_pix)
  );

  // Stage 1: capture the pixel request and its overlay flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_pix_idx <= '0;
      r_s1_sel_idx <= '0;
      r_s1_cursor  <= 1'b0;
      r_s1_palette <= 1'b0;
      r_s1_border  <= 1'b0;
    end else begin
      r_s1_valid   <= pix_valid;
      r_s1_pix_idx <= pix_idx;
      r_s1_sel_idx <= sel_idx;
      r_s1_cursor  <= is_cursor;
      r_s1_palette <= is_palette;
      r_s1_border  <= is_border;
    end
  end

`ifdef PALETTE_CURSOR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;

  // Blink timer: flip phase after BLINK_FRAMES frame ticks; phase 0 shows the cursor.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + BW'(1);
      end
    end
  end

  assign w_cursor_vis = ~r_blink_phase;
`else
  logic w_unused_blink;

  assign w_cursor_vis   = 1'b1;
  assign w_unused_blink = frame_tick ^ (BLINK_FRAMES == 0);
`endif

  // Stage 2: palette read (entries INIT has not reached yet read black) and
  // overlay priority cursor > palette swatch > border > framebuffer pixel.
  // Reading here means a write in cycle N is visible to pixels presented in N.
  always_comb begin
    w_sel_rgb = w_rd_sel;
    w_pix_rgb = w_rd_pix;
    w_color   = C_BLACK;
    if (w_init_active && (r_s1_sel_idx >= r_init_cnt)) begin
      w_sel_rgb = C_BLACK;
    end else begin
      w_sel_rgb = w_rd_sel;
    end
    if (w_init_active && (r_s1_pix_idx >= r_init_cnt)) begin
      w_pix_rgb = C_BLACK;
    end else begin
      w_pix_rgb = w_rd_pix;
    end
    if (r_s1_cursor && w_cursor_vis) begin
      w_color = C_GREEN;
    end else if (r_s1_palette) begin
      w_color = w_sel_rgb;
    end else if (r_s1_border) begin
      w_color = C_BLACK;
    end else begin
      w_color = w_pix_rgb;
    end
  end

  // Output register: colour updates only with a valid pixel, otherwise holds.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        {VGA_R, VGA_G, VGA_B} <= w_color;
      end
    end
  end

endmodule

// File: tb/tb_palette_lut.sv
// Directed self-checking bench for palette_lut (IDX_W=2, CH_W=10).
// Build with PALETTE_CURSOR_BLINK_EN to exercise the blink path.
module tb_palette_lut;

  localparam logic [29:0] K_WHITE = 30'h3FFF_FFFF;
  localparam logic [29:0] K_BLACK = 30'h0000_0000;
  localparam logic [29:0] K_RED   = 30'h3FF0_0000;
  localparam logic [29:0] K_BLUE  = 30'h0000_03FF;
  localparam logic [29:0] K_GREEN = 30'h000F_FC00;
  localparam logic [29:0] K_USR1  = 30'h1552_ABFF;  // (155,0AA,3FF)
  localparam logic [29:0] K_USR0  = 30'h0010_0803;  // (001,002,003)

  logic       Clk;
  logic       Reset;
  logic [1:0] sel_idx;
  logic [1:0] fb_wr_idx;
  logic       pix_valid;
  logic [1:0] pix_idx;
  logic       is_cursor, is_palette, is_border;
  logic       frame_tick;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_idx;
  logic [9:0] wr_r, wr_g, wr_b;
  logic       out_valid;
  logic [9:0] VGA_R, VGA_G, VGA_B;

  int n_checks;
  int n_errors;

  palette_lut #(
    .IDX_W        (2),
    .CH_W         (10),
    .BLINK_FRAMES (2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .sel_idx    (sel_idx),
    .fb_wr_idx  (fb_wr_idx),
    .pix_valid  (pix_valid),
    .pix_idx    (pix_idx),
    .is_cursor  (is_cursor),
    .is_palette (is_palette),
    .is_border  (is_border),
    .frame_tick (frame_tick),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_r       (wr_r),
    .wr_g       (wr_g),
    .wr_b       (wr_b),
    .out_valid  (out_valid),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One-cycle pixel pulse; output must appear exactly two edges later and then hold.
  task automatic do_pix(input string tag, input logic [1:0] p, input logic cur,
                        input logic pal, input logic brd, input logic [1:0] sel,
                        input logic [29:0] exp);
    pix_valid  = 1'b1;
    pix_idx    = p;
    is_cursor  = cur;
    is_palette = pal;
    is_border  = brd;
    sel_idx    = sel;
    step();
    pix_valid  = 1'b0;
    is_cursor  = 1'b0;
    is_palette = 1'b0;
    is_border  = 1'b0;
    chk({tag, "_v_n1"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, "_v_n2"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_rgb"}, {2'b00, VGA_R, VGA_G, VGA_B}, {2'b00, exp});
    step();
    chk({tag, "_v_n3"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_hold"}, {2'b00, VGA_R, VGA_G, VGA_B}, {2'b00, exp});
  endtask

  // Count edges after Reset release until wr_ready rises (bounded).
  task automatic wait_ready(input string tag, input int exp_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!wr_ready && n < 20);
    chk(tag, n, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] exp_c;
    n_checks   = 0;
    n_errors   = 0;
    Reset      = 1'b1;
    sel_idx    = 2'd0;
    pix_valid  = 1'b0;
    pix_idx    = 2'd0;
    is_cursor  = 1'b0;
    is_palette = 1'b0;
    is_border  = 1'b0;
    frame_tick = 1'b0;
    wr_valid   = 1'b0;
    wr_idx     = 2'd0;
    wr_r       = 10'd0;
    wr_g       = 10'd0;
    wr_b       = 10'd0;

    // Reset state
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rgb", {2'b00, VGA_R, VGA_G, VGA_B}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    Reset = 1'b0;
    wait_ready("init_cycles", 4);

    // fb_wr_idx is a straight combinational copy of sel_idx
    sel_idx = 2'd2;
    #1;
    chk("fb_idx2", {30'd0, fb_wr_idx}, 32'd2);
    sel_idx = 2'd3;
    #1;
    chk("fb_idx3", {30'd0, fb_wr_idx}, 32'd3);

    // Default palette and overlay priority
    do_pix("pix2_red",   2'd2, 1'b0, 1'b0, 1'b0, 2'd0, K_RED);
    do_pix("pix0_white", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, K_WHITE);
    do_pix("pix3_blue",  2'd3, 1'b0, 1'b0, 1'b0, 2'd0, K_BLUE);
    do_pix("cur_pal",    2'd0, 1'b1, 1'b1, 1'b0, 2'd3, K_GREEN);
    do_pix("border",     2'd0, 1'b0, 1'b0, 1'b1, 2'd0, K_BLACK);
    do_pix("pal_sel3",   2'd0, 1'b0, 1'b1, 1'b0, 2'd3, K_BLUE);
    do_pix("pal_brd",    2'd0, 1'b0, 1'b1, 1'b1, 2'd2, K_RED);

    // Write entry 1 in the cycle its earlier pixel is read: that pixel is
    // still black, pixels presented in the write cycle and after see the new colour.
    pix_valid = 1'b1;
    pix_idx   = 2'd1;
    step();
    wr_valid  = 1'b1;
    wr_idx    = 2'd1;
    wr_r      = 10'h155;
    wr_g      = 10'h0AA;
    wr_b      = 10'h3FF;
    chk("wr_ready_run", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid  = 1'b0;
    chk("wr_old_v", {31'd0, out_valid}, 32'd1);
    chk("wr_old_rgb", {2'b00, VGA_R, VGA_G, VGA_B}, {2'b00, K_BLACK});
    step();
    pix_valid = 1'b0;
    chk("wr_new_rgb", {2'b00, VGA_R, VGA_G, VGA_B}, {2'b00, K_USR1});
    step();
    chk("wr_new2_rgb", {2'b00, VGA_R, VGA_G, VGA_B}, {2'b00, K_USR1});
    step();
    chk("wr_idle_v", {31'd0, out_valid}, 32'd0);

    // Cursor across frame ticks (blink period 2 when enabled)
    for (int k = 0; k < 5; k++) begin
`ifdef PALETTE_CURSOR_BLINK_EN
      exp_c = (((k / 2) % 2) == 1) ? K_RED : K_GREEN;
`else
      exp_c = K_GREEN;
`endif
      do_pix($sformatf("blink_t%0d", k), 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, exp_c);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end

    // Reset mid-RUN discards user entries; a write held across Reset and INIT is never taken
    wr_valid = 1'b1;
    wr_idx   = 2'd0;
    wr_r     = 10'h001;
    wr_g     = 10'h002;
    wr_b     = 10'h003;
    step();
    wr_valid = 1'b0;
    do_pix("usr0", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, K_USR0);
    wr_valid = 1'b1;
    wr_idx   = 2'd2;
    wr_r     = 10'h155;
    wr_g     = 10'h155;
    wr_b     = 10'h155;
    Reset    = 1'b1;
    step();
    step();
    Reset    = 1'b0;
    wait_ready("reinit_cycles", 4);
    wr_valid = 1'b0;
    do_pix("reinit_e0", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, K_WHITE);
    do_pix("reinit_e2", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, K_RED);
    do_pix("reinit_e1", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, K_BLACK);

    // Reset during INIT restarts at entry 0
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    wait_ready("restart_cycles", 4);

    // Lookup during INIT: entry 3 not yet rewritten reads black
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    do_pix("init_rd3", 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, K_BLACK);
    wait_ready("init_tail", 1);
    do_pix("run_rd3", 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, K_BLUE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/palette_lut.md
PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 SHALL have parameter IDX_W, default 2, palette index width (2**IDX_W entries).
REQ-002 SHALL have parameter CH_W, default 10, width of each VGA colour channel.
REQ-003 SHALL have parameter BLINK_FRAMES, default 16, frames per cursor blink phase.
REQ-004 Ports: Clk  in  1  sole clock; all state on rising edge.
REQ-005 Ports: Reset  in  1  synchronous, active-high.
REQ-006 Ports: sel_idx  in  IDX_W  user-selected drawing colour.
REQ-007 Ports: fb_wr_idx  out  IDX_W  colour written into framebuffer.
REQ-008 Ports: pix_valid  in  1  pixel lookup request this cycle.
REQ-009 Ports: pix_idx  in  IDX_W  framebuffer readback index.
REQ-010 Ports: is_cursor, is_palette, is_border  in  1 each  overlay flags for the pixel.
REQ-011 Ports: frame_tick  in  1  one-cycle pulse per frame.
REQ-012 Ports: wr_valid  in  1 / wr_ready  out  1  palette-write handshake.
REQ-013 Ports: wr_idx  in  IDX_W / wr_r, wr_g, wr_b  in  CH_W  palette entry and colour.
REQ-014 Ports: out_valid  out  1 / VGA_R, VGA_G, VGA_B  out  CH_W  registered pixel colour.

Function
REQ-015 fb_wr_idx SHALL equal sel_idx combinationally.
REQ-016 Palette SHALL hold 2**IDX_W RGB entries in registers; default entries 0 white (all ones), 1 black, 2 red, 3 blue; entries 4 and above black.
REQ-017 FSM SHALL have two states: INIT and RUN. Reset enters INIT. INIT writes defaults to one entry per cycle, index 0 upward, then enters RUN after the last entry.
REQ-018 wr_ready SHALL be 0 in INIT and 1 in RUN.
REQ-019 A write SHALL be accepted only when wr_valid and wr_ready are both 1, and SHALL commit at that clock edge.
REQ-020 Pixel pipeline SHALL have fixed 2-cycle latency: out_valid at cycle N+2 equals pix_valid at cycle N.
REQ-021 The pipeline SHALL run in both INIT and RUN. Entries not yet initialised read as black.
REQ-022 Output priority SHALL be: cursor visible, then green (R=0, G=all ones, B=0); else is_palette, then palette[sel_idx]; else is_border, then black; else palette[pix_idx].
REQ-023 Palette reads SHALL happen in stage 2. A write committed at the edge ending cycle N SHALL be seen by pixels presented in cycle N or later; earlier pixels SHALL see the old value.
REQ-024 When out_valid=0, VGA_R/G/B SHALL hold their previous values.
REQ-025 A write and a lookup to the same index in the same cycle SHALL both complete; no stall, no drop.

Reset
REQ-026 On Reset=1 at an edge: out_valid=0, VGA_R/G/B=0, pipeline valids cleared, INIT counter=0, blink counter=0, blink phase=visible.
REQ-027 Reset mid-RUN SHALL discard user-written entries by re-running INIT to defaults.
REQ-028 Reset asserted during INIT SHALL restart INIT at entry 0.
REQ-029 A write request pending at Reset SHALL be ignored.

Configuration
REQ-030 Macro PALETTE_CURSOR_BLINK_EN defined: a counter SHALL count frame_tick pulses and toggle cursor visibility every BLINK_FRAMES ticks; the cursor SHALL be visible in phase 0.
REQ-031 In that phase, an invisible cursor SHALL fall through to the next priority level.
REQ-032 Macro PALETTE_CURSOR_BLINK_EN undefined: the cursor SHALL always be visible, frame_tick SHALL be ignored, and no blink logic SHALL exist.

Structure
REQ-033 Shared package palette_pkg SHALL hold the rgb_t struct typedef (parameterised by CH_W via localparam default 10), the default colour constants (WHITE, BLACK, RED, BLUE, CURSOR_GREEN), and the FSM state enum.
REQ-034 One sub-module, palette_regfile, SHALL be used: 2**IDX_W entries, one write port, two asynchronous read ports (sel_idx, pix_idx).

Verification
REQ-035 Reset, then count cycles until wr_ready=1 -> exactly 4 cycles (IDX_W=2); lookup pix_idx=2 afterwards -> R=3FF, G=0, B=0.
REQ-036 pix_valid pulse at cycle 10 with is_cursor=1, is_palette=1 -> out_valid=1 only at cycle 12, colour 000/3FF/000.
REQ-037 Write idx 1 = (155,0AA,3FF) in same cycle as lookup pix_idx=1 -> that pixel is black; next-cycle lookup returns (155,0AA,3FF).
REQ-038 is_border=1, pix_idx=0 -> black; is_palette=1, sel_idx=3 -> blue.
REQ-039 Write idx 0, assert Reset, wait for INIT -> entry 0 white again; wr_valid held high during INIT never accepted.
REQ-040 With PALETTE_CURSOR_BLINK_EN defined and BLINK_FRAMES=2: cursor pixel green for ticks 0-1, then palette[pix_idx] for ticks 2-3, then green again.
